regfile_mport_clr: RTL and testbench
====================================

Name: regfile_mport_clr

Overview:
Parametrised multi-port register file with a hardware clear sequencer. Serves as the table store for the branch-predictor benchmark, such as PHT counters, BTB tags and history tables. Provides p_num_rd combinational read ports and p_num_wr clocked write ports, with optional write-to-read bypass. A sequential clear sweep writes p_init_value into every entry after reset or on request, with a busy indication while the sweep runs.

Parameters:
p_data_nbits, 32, width of each entry
p_num_entries, 32, number of entries; need not be a power of two; must be >= 2
p_num_rd, 2, number of read ports (>= 1)
p_num_wr, 1, number of write ports (>= 1)
p_init_value, 0, value written to every entry by a clear sweep (p_data_nbits wide)
p_bypass, 1, 1 = same-cycle write data is forwarded to matching reads; 0 = reads return stored contents only
c_addr_nbits, $clog2(p_num_entries), local constant, not set from outside

Ports:
clk  in  1  clock, all state updates on the rising edge
reset  in  1  synchronous, active-low: sampled 0 on a rising edge = reset asserted
rd_addr  in  p_num_rd*c_addr_nbits  read addresses; port i occupies bits [i*c_addr_nbits +: c_addr_nbits]
rd_data  out  p_num_rd*p_data_nbits  read data, combinational, packed the same way
wr_en  in  p_num_wr  per-port write enable
wr_addr  in  p_num_wr*c_addr_nbits  write addresses, packed per port
wr_data  in  p_num_wr*p_data_nbits  write data, packed per port
clr  in  1  request a clear sweep; honoured only when idle
busy  out  1  1 while a clear sweep is pending or in progress

Behaviour:
- FSM has two states: CLEAR and IDLE. Sweep pointer ptr is c_addr_nbits wide.
- Reset (reset==0 at an edge):
  - state <= CLEAR, ptr <= 0.
  - No entry is written.
  - busy = 1 while in reset. busy is a registered/state-derived output and is 1 out of reset.
  - Reset mid-sweep restarts the sweep from entry 0.
- CLEAR (reset==1):
  - Each edge writes entry[ptr] <= p_init_value and increments ptr.
  - At the edge where ptr == p_num_entries-1, the last entry is written and state <= IDLE.
  - A sweep therefore takes exactly p_num_entries edges after reset deasserts. busy falls after the final write.
- IDLE:
  - clr==1 at an edge: state <= CLEAR, ptr <= 0, busy = 1 from the next cycle.
  - Writes presented in that same clr cycle are still performed. They are overwritten later by the sweep.
- While busy==1:
  - All wr_en are ignored; nothing is written except by the sweep.
  - clr is ignored.
  - Every rd_data port returns p_init_value regardless of address. The table is logically cleared.
- Writes (IDLE only):
  - Each port with wr_en=1 writes its wr_data to its wr_addr at the edge.
  - When two or more ports target the same address, the highest-indexed port wins.
- Reads (IDLE):
  - rd_data[i] = entry[rd_addr[i]], combinational, zero latency.
  - Any number of ports may read the same address.
- Bypass (p_bypass=1, IDLE):
  - If any enabled write port targets rd_addr[i] in the same cycle, rd_data[i] returns that port's wr_data instead of the stored value.
  - With several matching write ports, the highest-indexed port is returned, consistent with the write priority.
  - With p_bypass=0, reads return the pre-edge stored value.
- Out-of-range addresses (>= p_num_entries, non-power-of-two depths only):
  - Writes are dropped.
  - Reads return 0 (not p_init_value), except while busy, when reads return p_init_value.
- Entry contents before the first completed sweep are never observable, because of busy masking.

Test Plan:
- Reset held low for 3 cycles, then released, with p_num_entries=32 and p_init_value=8'h5A: busy=1 for exactly 32 cycles after release, then 0. All rd ports read 8'h5A at every address 0..31. Writes attempted during busy are lost.
- Idle, p_num_wr=2: wr0 writes addr 3 = 0x11 and wr1 writes addr 3 = 0x22 in the same cycle -> next cycle addr 3 reads 0x22. Separate writes to addrs 4 and 5 both land.
- Bypass: with p_bypass=1, rd0=7 while wr0 writes addr 7 = 0xDEAD -> rd_data0 = 0xDEAD in the same cycle. Same stimulus with p_bypass=0 -> rd_data0 shows the old value and 0xDEAD appears next cycle.
- clr pulse in IDLE with table filled with 0x1..0x20: busy rises next cycle and lasts 32 cycles. A second clr pulse mid-sweep is ignored, so the sweep still ends at 32 cycles. All entries then read p_init_value.
- Reset asserted at sweep step 10 for 1 cycle: busy stays 1 and the sweep restarts at entry 0, completing 32 cycles after release.
- p_num_entries=24: write addr 30 = 0xFF is dropped. Reading addr 30 returns 0 when idle and p_init_value while busy. Addr 23 is writable and readable.

Source files
------------

// File: rtl/regfile_mport_clr.sv
// Multi-port register file with combinational reads, prioritised clocked writes, optional
// write-to-read bypass and a sequential clear sweep that fills every entry with p_init_value.
module regfile_mport_clr #(
    parameter int unsigned               p_data_nbits  = 32,
    parameter int unsigned               p_num_entries = 32,
    parameter int unsigned               p_num_rd      = 2,
    parameter int unsigned               p_num_wr      = 1,
    parameter logic [p_data_nbits-1:0]   p_init_value  = '0,
    parameter bit                        p_bypass      = 1'b1,
    localparam int unsigned              c_addr_nbits  = $clog2(p_num_entries)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [p_num_rd*c_addr_nbits-1:0] rd_addr,
    output logic [p_num_rd*p_data_nbits-1:0] rd_data,
    input  logic [p_num_wr-1:0]              wr_en,
    input  logic [p_num_wr*c_addr_nbits-1:0] wr_addr,
    input  logic [p_num_wr*p_data_nbits-1:0] wr_data,
    input  logic                             clr,
    output logic                             busy
);

    localparam logic [c_addr_nbits-1:0] c_last = c_addr_nbits'(p_num_entries - 1);

    typedef enum logic [0:0] {StClear, StIdle} state_e;

    state_e                  state_q, state_d;
    logic [c_addr_nbits-1:0] ptr_q, ptr_d;
    logic [p_data_nbits-1:0] mem_q [p_num_entries];

    // Widen before comparing so power-of-two depths do not yield a constant compare.
    function automatic logic in_range(input logic [c_addr_nbits-1:0] a);
        return 32'(a) < p_num_entries;
    endfunction

    assign busy = (state_q == StClear);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            StClear: begin
                ptr_d = ptr_q + c_addr_nbits'(1);
                if (ptr_q == c_last) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (clr) begin
                    state_d = StClear;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = StClear;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StClear;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Later ports are assigned last, so the highest-indexed port wins on collisions.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (busy) begin
                mem_q[ptr_q] <= p_init_value;
            end else begin
                for (int unsigned p = 0; p < p_num_wr; p++) begin
                    if (wr_en[p] && in_range(wr_addr[p*c_addr_nbits +: c_addr_nbits])) begin
                        mem_q[wr_addr[p*c_addr_nbits +: c_addr_nbits]] <=
                            wr_data[p*p_data_nbits +: p_data_nbits];
                    end
                end
            end
        end
    end

    always_comb begin
        logic [c_addr_nbits-1:0] ra;
        logic [p_data_nbits-1:0] val;
        rd_data = '0;
        ra      = '0;
        val     = '0;
        for (int unsigned i = 0; i < p_num_rd; i++) begin
            ra  = rd_addr[i*c_addr_nbits +: c_addr_nbits];
            val = '0;
            if (busy) begin
                val = p_init_value;
            end else if (in_range(ra)) begin
                val = mem_q[ra];
                if (p_bypass) begin
                    for (int unsigned p = 0; p < p_num_wr; p++) begin
                        if (wr_en[p] && (wr_addr[p*c_addr_nbits +: c_addr_nbits] == ra)) begin
                            val = wr_data[p*p_data_nbits +: p_data_nbits];
                        end
                    end
                end
            end
            rd_data[i*p_data_nbits +: p_data_nbits] = val;
        end
    end

endmodule

// File: tb/tb_regfile_mport_clr.sv
// Bench for regfile_mport_clr: three instances (bypass, no bypass, 24-deep) share stimulus
// and are compared against a per-instance table model plus fixed expectation vectors.
module tb_regfile_mport_clr;

    localparam logic [15:0] Init = 16'h005A;

    logic        clk = 1'b0;
    logic        reset, clr;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr, rd_addr;
    logic [31:0] wr_data;
    logic [31:0] rd_m, rd_n, rd_s;
    logic        busy_m, busy_n, busy_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_mport_clr #(
        .p_data_nbits(16), .p_num_entries(32), .p_num_rd(2), .p_num_wr(2),
        .p_init_value(Init), .p_bypass(1'b1)
    ) u_m (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_m), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .clr(clr), .busy(busy_m)
    );

    regfile_mport_clr #(
        .p_data_nbits(16), .p_num_entries(32), .p_num_rd(2), .p_num_wr(2),
        .p_init_value(Init), .p_bypass(1'b0)
    ) u_n (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_n), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .clr(clr), .busy(busy_n)
    );

    regfile_mport_clr #(
        .p_data_nbits(16), .p_num_entries(24), .p_num_rd(2), .p_num_wr(2),
        .p_init_value(Init), .p_bypass(1'b1)
    ) u_s (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_s), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .clr(clr), .busy(busy_s)
    );

    // Model: table contents plus the number of sweep edges still outstanding.
    logic [15:0] mem [3][32];
    int          left [3];
    int          nent [3];
    bit          byp  [3];

    function automatic logic [15:0] exp_rd(input int d, input logic [4:0] a);
        logic [15:0] v;
        if (left[d] > 0) return Init;
        if (int'(a) >= nent[d]) return 16'h0000;
        v = mem[d][a];
        if (byp[d]) begin
            for (int p = 0; p < 2; p++) begin
                if (wr_en[p] && wr_addr[p*5 +: 5] == a) v = wr_data[p*16 +: 16];
            end
        end
        return v;
    endfunction

    task automatic model_update();
        for (int d = 0; d < 3; d++) begin
            if (!reset) begin
                left[d] = nent[d];
            end else if (left[d] > 0) begin
                left[d]--;
                if (left[d] == 0) begin
                    for (int e = 0; e < 32; e++) mem[d][e] = Init;
                end
            end else begin
                for (int p = 0; p < 2; p++) begin
                    if (wr_en[p] && int'(wr_addr[p*5 +: 5]) < nent[d])
                        mem[d][wr_addr[p*5 +: 5]] = wr_data[p*16 +: 16];
                end
                if (clr) left[d] = nent[d];
            end
        end
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d] actual=%h required=%h", name, idx, act, exp);
        end
    endtask

    task automatic check_model();
        logic        b;
        logic [31:0] r;
        for (int d = 0; d < 3; d++) begin
            b = (d == 0) ? busy_m : (d == 1) ? busy_n : busy_s;
            r = (d == 0) ? rd_m : (d == 1) ? rd_n : rd_s;
            chk("busy", d, {31'b0, b}, {31'b0, left[d] > 0});
            for (int i = 0; i < 2; i++)
                chk("rd_data", d, {16'b0, r[i*16 +: 16]}, {16'b0, exp_rd(d, rd_addr[i*5 +: 5])});
        end
    endtask

    // Called at a falling edge with inputs already set.
    task automatic tick();
        #1;
        check_model();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic count_sweep(input int clr_at, input int rst_at, input int wr_until,
                               output int nm, output int ns);
        nm = 0;
        ns = 0;
        for (int k = 0; k < 200; k++) begin
            clr     = (k == clr_at);
            reset   = !(k == rst_at);
            wr_en   = (k < wr_until) ? 2'b11 : 2'b00;
            wr_addr = 10'($urandom);
            wr_data = $urandom;
            rd_addr = 10'($urandom);
            #1;
            if (!busy_m && !busy_s) break;
            if (busy_m) nm++;
            if (busy_s) ns++;
            tick();
        end
        clr   = 1'b0;
        reset = 1'b1;
        wr_en = 2'b00;
    endtask

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [15:0] wd0;
        logic [4:0]  wa1;
        logic [15:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [15:0] em0, em1, en0, en1, es0, es1;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nm, ns, pool;
        nent = '{32, 32, 24};
        byp  = '{1'b1, 1'b0, 1'b1};
        for (int d = 0; d < 3; d++) begin
            left[d] = nent[d];
            for (int e = 0; e < 32; e++) mem[d][e] = 16'h0;
        end
        vecs[0] = '{2'b11, 5'd3,  16'h0011, 5'd3,  16'h0022, 5'd3,  5'd4,
                    16'h0022, Init, Init, Init, 16'h0022, Init};
        vecs[1] = '{2'b11, 5'd4,  16'h0044, 5'd5,  16'h0055, 5'd3,  5'd5,
                    16'h0022, 16'h0055, 16'h0022, Init, 16'h0022, 16'h0055};
        vecs[2] = '{2'b01, 5'd7,  16'hDEAD, 5'd0,  16'h0000, 5'd7,  5'd4,
                    16'hDEAD, 16'h0044, Init, 16'h0044, 16'hDEAD, 16'h0044};
        vecs[3] = '{2'b00, 5'd0,  16'h0000, 5'd0,  16'h0000, 5'd7,  5'd5,
                    16'hDEAD, 16'h0055, 16'hDEAD, 16'h0055, 16'hDEAD, 16'h0055};
        vecs[4] = '{2'b01, 5'd30, 16'h00FF, 5'd0,  16'h0000, 5'd30, 5'd23,
                    16'h00FF, Init, Init, Init, 16'h0000, Init};
        vecs[5] = '{2'b10, 5'd0,  16'h0000, 5'd23, 16'h2323, 5'd30, 5'd23,
                    16'h00FF, 16'h2323, 16'h00FF, Init, 16'h0000, 16'h2323};
        vecs[6] = '{2'b00, 5'd0,  16'h0000, 5'd0,  16'h0000, 5'd30, 5'd23,
                    16'h00FF, 16'h2323, 16'h00FF, 16'h2323, 16'h0000, 16'h2323};

        reset   = 1'b0;
        clr     = 1'b0;
        wr_en   = 2'b00;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        @(posedge clk);
        model_update();
        @(negedge clk);
        tick();
        tick();

        // Release reset; writes during the first 20 busy cycles must be lost.
        count_sweep(-1, -1, 20, nm, ns);
        chk("reset_sweep_len32", 0, nm, 32);
        chk("reset_sweep_len24", 2, ns, 24);

        for (int i = 0; i < 7; i++) begin
            wr_en   = vecs[i].we;
            wr_addr = {vecs[i].wa1, vecs[i].wa0};
            wr_data = {vecs[i].wd1, vecs[i].wd0};
            rd_addr = {vecs[i].ra1, vecs[i].ra0};
            #1;
            chk("vec_m0", i, {16'b0, rd_m[15:0]},  {16'b0, vecs[i].em0});
            chk("vec_m1", i, {16'b0, rd_m[31:16]}, {16'b0, vecs[i].em1});
            chk("vec_n0", i, {16'b0, rd_n[15:0]},  {16'b0, vecs[i].en0});
            chk("vec_n1", i, {16'b0, rd_n[31:16]}, {16'b0, vecs[i].en1});
            chk("vec_s0", i, {16'b0, rd_s[15:0]},  {16'b0, vecs[i].es0});
            chk("vec_s1", i, {16'b0, rd_s[31:16]}, {16'b0, vecs[i].es1});
            tick();
        end

        for (int i = 0; i < 32; i++) begin
            wr_en   = 2'b01;
            wr_addr = {5'd0, 5'(i)};
            wr_data = {16'd0, 16'(i + 1)};
            rd_addr = {5'(31 - i), 5'(i)};
            tick();
        end
        wr_en = 2'b00;
        for (int i = 0; i < 32; i++) begin
            rd_addr = {5'(i), 5'(31 - i)};
            tick();
        end

        // clr pulse; a second clr mid-sweep must not extend the sweep.
        clr = 1'b1;
        tick();
        clr     = 1'b0;
        rd_addr = {5'd23, 5'd30};
        #1;
        chk("oor_read_busy", 2, {16'b0, rd_s[15:0]}, {16'b0, Init});
        count_sweep(5, -1, 0, nm, ns);
        chk("clr_sweep_len32", 0, nm, 32);
        chk("clr_sweep_len24", 2, ns, 24);
        for (int i = 0; i < 32; i++) begin
            rd_addr = {5'(i), 5'(i)};
            tick();
        end

        // Reset for one cycle at sweep step 10 restarts the sweep.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        count_sweep(-1, 10, 0, nm, ns);
        chk("rst_mid_sweep_len32", 0, nm, 43);
        chk("rst_mid_sweep_len24", 2, ns, 35);

        for (int c = 0; c < 1500; c++) begin
            pool    = $urandom_range(0, 31);
            reset   = ($urandom_range(0, 299) != 0);
            clr     = ($urandom_range(0, 59) == 0);
            wr_en   = 2'($urandom);
            wr_addr = {($urandom_range(0, 1) != 0) ? 5'(pool) : 5'($urandom_range(0, 31)),
                       ($urandom_range(0, 1) != 0) ? 5'(pool) : 5'($urandom_range(0, 31))};
            wr_data = $urandom;
            rd_addr = {($urandom_range(0, 1) != 0) ? 5'(pool) : 5'($urandom_range(0, 31)),
                       ($urandom_range(0, 1) != 0) ? 5'(pool) : 5'($urandom_range(0, 31))};
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
